moldudp64_header_parser: RTL and testbench
==========================================

Name: moldudp64_header_parser

Overview:
Parametrised successor to the fixed-beat MoldUDP64 header decoder. Extracts the 20-byte MoldUDP64 header (session 10 B, sequence 8 B, count 2 B) from a framed beat stream. The header may sit at any byte offset and the stream may be any whole-byte width. Tracks the expected sequence number per session and flags gaps, stale/duplicate packets, heartbeats and end-of-session. The block sits between the Ethernet/IP/UDP framer and the ITCH message splitter.

Parameters:
DATA_W, 64, stream width in bits; must be a multiple of 8 and at least 32.
HDR_OFFSET, 42, byte index of the first MoldUDP64 byte, counted from the SOP beat. Default is 14 Eth + 20 IP + 8 UDP.
BEAT_CNT_W, 8, width of the beat counter; the counter saturates at its maximum.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  beat qualifier; no handshake back-pressure, the block always accepts
in_sop  in  1  first beat of packet, qualified by in_valid
in_eop  in  1  last beat of packet, qualified by in_valid
in_data  in  DATA_W  beat data; byte lane k = in_data[8k+7:8k] is wire byte (beat*DATA_W/8 + k)
hdr_valid  out  1  one-cycle pulse; all hdr_* and flag outputs are valid in that cycle and hold until the next pulse
session_id  out  80  session, network byte order converted to a numeric value (first wire byte = MSB)
seq_num  out  64  sequence number, big-endian converted
msg_count  out  16  message count, big-endian converted
is_heartbeat  out  1  msg_count == 0
is_end_session  out  1  msg_count == 16'hFFFF
seq_gap  out  1  seq_num > expected
gap_len  out  64  seq_num - expected when seq_gap, else 0
seq_stale  out  1  seq_num < expected (duplicate or retransmission)
session_change  out  1  session_id differs from the tracked session, or first header since reset
trunc_err  out  1  one-cycle pulse: EOP or new SOP arrived before the header was complete
expected_seq  out  64  current expected next sequence number

Behaviour:
- Reset: all outputs 0. Tracker is unsynchronised. FSM goes to IDLE. Reset mid-packet discards the packet with no pulses.
- FSM states:
  - IDLE: waits for in_valid & in_sop.
  - HDR: collecting header bytes.
  - BODY: header done, waits for EOP.
- IDLE to HDR on SOP (SOP beat = beat 0). If the whole header falls inside the SOP beat, go directly to BODY, or to IDLE if EOP is also set.
- HDR to BODY on the beat that delivers header byte 19. BODY to IDLE on EOP.
- Byte capture: on each valid beat, every lane with absolute index i in [HDR_OFFSET, HDR_OFFSET+20) writes header byte i-HDR_OFFSET into a 160-bit buffer. Lanes outside that range are ignored.
- Latency: hdr_valid and all fields/flags are registered and assert exactly 1 cycle after the beat carrying header byte 19.
- in_valid low: no state, counter or buffer change.
- SOP while in HDR: pulse trunc_err, restart capture with this beat as beat 0.
- SOP while in BODY: treat as a new packet; no error.
- EOP while in HDR (same beat, header incomplete): pulse trunc_err, go to IDLE, no hdr_valid, tracker unchanged.
- EOP and SOP in the same beat: single-beat packet; evaluate normally.
- Sequence tracking on header completion:
  - Unsynchronised or session_change: session_change=1, no gap/stale, expected = seq + count.
  - seq == expected: expected += count.
  - seq > expected: seq_gap=1, gap_len=seq-expected, expected = seq + count (resync forward).
  - seq < expected: seq_stale=1, expected unchanged.
  - Heartbeat (count 0): gap/stale evaluated; expected = max(expected, seq).
  - End-of-session (count FFFF): gap/stale evaluated; count is NOT added; tracker goes to unsynchronised after the pulse.
- Arithmetic: 64-bit modulo 2^64. Comparison is unsigned; no wrap handling is required.

Decomposition:
- Package moldudp64_pkg:
  - MOLD_HDR_BYTES=20
  - field byte offsets (SESSION=0, SEQ=10, COUNT=18)
  - MOLD_END_OF_SESSION=16'hFFFF
  - FSM state enum {IDLE, HDR, BODY}
- Sub-module moldudp64_seq_tracker: takes a session/seq/count strobe; holds expected_seq, tracked session and sync bit; produces the gap/stale/session_change/gap_len flags. The parser registers the flags alongside the fields.

Test Plan:
- Default params, SOP + 9 beats; header bytes 42..61 = session "TESTSESS01", seq 1, count 3 → hdr_valid 1 cycle after beat 7; seq_num=1, msg_count=3, session_change=1, expected_seq=4.
- Follow-up same session: seq 4/count 2, then seq 10/count 1 → 2nd header clean with expected 6. 3rd header: seq_gap=1, gap_len=4, expected_seq=11.
- Then seq 5/count 1 → seq_stale=1, expected_seq stays 11. Then heartbeat seq 11/count 0 → is_heartbeat=1, no gap, expected 11.
- EOP on beat 6 (header incomplete) → trunc_err pulse, no hdr_valid, expected_seq unchanged. Also SOP on beat 6 → trunc_err, new packet parsed correctly.
- count FFFF at seq 11 → is_end_session=1. Next packet, same session, seq 1 → session_change=1, no stale.
- DATA_W=128, HDR_OFFSET=0, in_valid toggling every other cycle, rst asserted between beats 0 and 1 → outputs 0, no hdr_valid. Repeated packet with no reset → header correct, pulse 1 cycle after beat 1.

Source files
------------

// File: rtl/moldudp64_pkg.sv
// Shared MoldUDP64 header constants, header payload type and FSM encoding.
package moldudp64_pkg;

    localparam int unsigned MOLD_HDR_BYTES   = 20;
    localparam int unsigned MOLD_HDR_W       = 8 * MOLD_HDR_BYTES;

    localparam int unsigned MOLD_SESSION_OFS = 0;
    localparam int unsigned MOLD_SEQ_OFS     = 10;
    localparam int unsigned MOLD_COUNT_OFS   = 18;

    localparam int unsigned MOLD_SESSION_W   = 80;
    localparam int unsigned MOLD_SEQ_W       = 64;
    localparam int unsigned MOLD_COUNT_W     = 16;

    localparam logic [MOLD_COUNT_W-1:0] MOLD_END_OF_SESSION = 16'hFFFF;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HDR  = 2'd1;
    localparam state_t ST_BODY = 2'd2;

    typedef struct packed {
        logic [MOLD_SESSION_W-1:0] session;
        logic [MOLD_SEQ_W-1:0]     seq;
        logic [MOLD_COUNT_W-1:0]   count;
    } mold_hdr_t;

    // Header buffer holds wire byte 0 in the top byte; slice fields by wire offset.
    function automatic mold_hdr_t mold_hdr_unpack(input logic [MOLD_HDR_W-1:0] raw);
        mold_hdr_t h;
        h.session = raw[MOLD_HDR_W - 1 - 8 * MOLD_SESSION_OFS -: MOLD_SESSION_W];
        h.seq     = raw[MOLD_HDR_W - 1 - 8 * MOLD_SEQ_OFS     -: MOLD_SEQ_W];
        h.count   = raw[MOLD_HDR_W - 1 - 8 * MOLD_COUNT_OFS   -: MOLD_COUNT_W];
        return h;
    endfunction

endpackage

// File: rtl/moldudp64_seq_tracker.sv
// Per-session expected-sequence tracker; flags are combinational against the
// current tracker state, state advances on the header strobe.
module moldudp64_seq_tracker
    import moldudp64_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_strobe,
    input  mold_hdr_t             i_hdr,
    output logic                  o_session_change_c,
    output logic                  o_seq_gap_c,
    output logic                  o_seq_stale_c,
    output logic [MOLD_SEQ_W-1:0] o_gap_len_c,
    output logic [MOLD_SEQ_W-1:0] o_expected_seq
);

    logic                      r_sync;
    logic [MOLD_SESSION_W-1:0] r_session;
    logic [MOLD_SEQ_W-1:0]     r_expected;
    logic [MOLD_SEQ_W-1:0]     w_expected_n;
    logic                      w_is_hb;
    logic                      w_is_eos;

    // Classify the incoming header and compute the next expected sequence.
    always_comb begin
        w_is_hb            = (i_hdr.count == '0);
        w_is_eos           = (i_hdr.count == MOLD_END_OF_SESSION);
        o_session_change_c = !r_sync || (i_hdr.session != r_session);
        o_seq_gap_c        = !o_session_change_c && (i_hdr.seq > r_expected);
        o_seq_stale_c      = !o_session_change_c && (i_hdr.seq < r_expected);
        o_gap_len_c        = o_seq_gap_c ? (i_hdr.seq - r_expected) : '0;
        w_expected_n       = r_expected;
        if (o_session_change_c) begin
            w_expected_n = w_is_eos ? i_hdr.seq : i_hdr.seq + MOLD_SEQ_W'(i_hdr.count);
        end else if (w_is_hb || w_is_eos) begin
            if (o_seq_gap_c) w_expected_n = i_hdr.seq;
        end else if (!o_seq_stale_c) begin
            w_expected_n = i_hdr.seq + MOLD_SEQ_W'(i_hdr.count);
        end
    end

    // Tracker state; end-of-session drops sync so the next header resynchronises.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= 1'b0;
            r_session  <= '0;
            r_expected <= '0;
        end else if (i_strobe) begin
            r_sync     <= !w_is_eos;
            r_session  <= i_hdr.session;
            r_expected <= w_expected_n;
        end
    end

    assign o_expected_seq = r_expected;

endmodule

// File: rtl/moldudp64_header_parser.sv
// MoldUDP64 header extractor: gathers the 20 header bytes from any byte offset
// of a framed beat stream and reports fields plus sequence-tracking flags.
module moldudp64_header_parser
    import moldudp64_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned HDR_OFFSET = 42,
    parameter int unsigned BEAT_CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_sop,
    input  logic                      in_eop,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      hdr_valid,
    output logic [MOLD_SESSION_W-1:0] session_id,
    output logic [MOLD_SEQ_W-1:0]     seq_num,
    output logic [MOLD_COUNT_W-1:0]   msg_count,
    output logic                      is_heartbeat,
    output logic                      is_end_session,
    output logic                      seq_gap,
    output logic [MOLD_SEQ_W-1:0]     gap_len,
    output logic                      seq_stale,
    output logic                      session_change,
    output logic                      trunc_err,
    output logic [MOLD_SEQ_W-1:0]     expected_seq
);

    localparam int unsigned LANES     = DATA_W / 8;
    localparam int unsigned LAST_BEAT = (HDR_OFFSET + MOLD_HDR_BYTES - 1) / LANES;
    localparam logic [BEAT_CNT_W-1:0] BEAT_MAX  = '1;
    localparam logic [BEAT_CNT_W-1:0] BEAT_LAST = BEAT_CNT_W'(LAST_BEAT);

    state_t                  r_state;
    state_t                  w_state_n;
    logic [BEAT_CNT_W-1:0]   r_beat;
    logic [BEAT_CNT_W-1:0]   w_beat_idx;
    logic [MOLD_HDR_W-1:0]   r_buf;
    logic [MOLD_HDR_W-1:0]   w_buf_n;
    logic [31:0]             w_lane_rel;
    logic                    w_capture;
    logic                    w_done;
    logic                    w_trunc;
    mold_hdr_t               w_hdr;
    logic                    w_session_change;
    logic                    w_seq_gap;
    logic                    w_seq_stale;
    logic [MOLD_SEQ_W-1:0]   w_gap_len;

    // An SOP beat is always beat 0, whatever the counter says.
    assign w_beat_idx = in_sop ? '0 : r_beat;
    assign w_capture  = in_valid && (in_sop || (r_state == ST_HDR));
    assign w_hdr      = mold_hdr_unpack(w_buf_n);

    // Merge header bytes carried by this beat into the buffer image.
    always_comb begin
        w_buf_n    = r_buf;
        w_lane_rel = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            // Below-offset lanes wrap to huge values, so one compare bounds both ends.
            w_lane_rel = 32'(w_beat_idx) * LANES + k - HDR_OFFSET;
            if (w_lane_rel < MOLD_HDR_BYTES) begin
                w_buf_n[MOLD_HDR_W - 1 - 8 * w_lane_rel -: 8] = in_data[8 * k +: 8];
            end
        end
    end

    // Next-state, header-complete and truncation decode.
    always_comb begin
        w_state_n = r_state;
        w_done    = 1'b0;
        w_trunc   = 1'b0;
        if (in_valid) begin
            if (in_sop || (r_state == ST_HDR)) begin
                if (in_sop && (r_state == ST_HDR)) w_trunc = 1'b1;
                if (w_beat_idx == BEAT_LAST) begin
                    w_done    = 1'b1;
                    w_state_n = in_eop ? ST_IDLE : ST_BODY;
                end else if (in_eop) begin
                    w_trunc   = 1'b1;
                    w_state_n = ST_IDLE;
                end else begin
                    w_state_n = ST_HDR;
                end
            end else if (r_state == ST_BODY) begin
                if (in_eop) w_state_n = ST_IDLE;
            end else if (r_state != ST_IDLE) begin
                w_state_n = ST_IDLE;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_n;
    end

    // Saturating beat counter and header byte buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
            r_buf  <= '0;
        end else begin
            if (in_valid) begin
                r_beat <= (w_beat_idx == BEAT_MAX) ? BEAT_MAX : w_beat_idx + BEAT_CNT_W'(1);
            end
            if (w_capture) r_buf <= w_buf_n;
        end
    end

    moldudp64_seq_tracker u_tracker (
        .clk                (clk),
        .rst                (rst),
        .i_strobe           (w_done),
        .i_hdr              (w_hdr),
        .o_session_change_c (w_session_change),
        .o_seq_gap_c        (w_seq_gap),
        .o_seq_stale_c      (w_seq_stale),
        .o_gap_len_c        (w_gap_len),
        .o_expected_seq     (expected_seq)
    );

    // Registered result: pulses for one cycle, fields and flags hold until the next header.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_valid      <= 1'b0;
            trunc_err      <= 1'b0;
            session_id     <= '0;
            seq_num        <= '0;
            msg_count      <= '0;
            is_heartbeat   <= 1'b0;
            is_end_session <= 1'b0;
            seq_gap        <= 1'b0;
            gap_len        <= '0;
            seq_stale      <= 1'b0;
            session_change <= 1'b0;
        end else begin
            hdr_valid <= w_done;
            trunc_err <= w_trunc;
            if (w_done) begin
                session_id     <= w_hdr.session;
                seq_num        <= w_hdr.seq;
                msg_count      <= w_hdr.count;
                is_heartbeat   <= (w_hdr.count == '0);
                is_end_session <= (w_hdr.count == MOLD_END_OF_SESSION);
                seq_gap        <= w_seq_gap;
                gap_len        <= w_gap_len;
                seq_stale      <= w_seq_stale;
                session_change <= w_session_change;
            end
        end
    end

endmodule

// File: tb/tb_moldudp64_header_parser.sv
// Bench for moldudp64_header_parser: directed table, truncation/reset sequences,
// and randomized packets checked against a sequence-tracking reference model.
`timescale 1ns/1ps
module tb_moldudp64_header_parser;

    localparam int unsigned W1    = 64;
    localparam int unsigned OFS1  = 42;
    localparam int unsigned NB1   = W1 / 8;
    localparam int          LAST1 = (OFS1 + 19) / NB1;
    localparam int unsigned W2    = 128;

    localparam logic [79:0] S1 = "TESTSESS01";
    localparam logic [79:0] S2 = "SESSION002";

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: default parameters
    logic          rst1, v1, sop1, eop1;
    logic [W1-1:0] d1;
    logic          hv1, hb1, eos1, gap1, st1, sc1, tr1;
    logic [79:0]   sid1;
    logic [63:0]   seq1, gl1, ex1;
    logic [15:0]   cnt1;

    // DUT 2: wide bus, header at byte 0
    logic          rst2, v2, sop2, eop2;
    logic [W2-1:0] d2;
    logic          hv2, hb2, eos2, gap2, st2, sc2, tr2;
    logic [79:0]   sid2;
    logic [63:0]   seq2, gl2, ex2;
    logic [15:0]   cnt2;

    moldudp64_header_parser #(.DATA_W(W1), .HDR_OFFSET(OFS1), .BEAT_CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst1), .in_valid(v1), .in_sop(sop1), .in_eop(eop1), .in_data(d1),
        .hdr_valid(hv1), .session_id(sid1), .seq_num(seq1), .msg_count(cnt1),
        .is_heartbeat(hb1), .is_end_session(eos1), .seq_gap(gap1), .gap_len(gl1),
        .seq_stale(st1), .session_change(sc1), .trunc_err(tr1), .expected_seq(ex1)
    );

    moldudp64_header_parser #(.DATA_W(W2), .HDR_OFFSET(0), .BEAT_CNT_W(8)) u_dut2 (
        .clk(clk), .rst(rst2), .in_valid(v2), .in_sop(sop2), .in_eop(eop2), .in_data(d2),
        .hdr_valid(hv2), .session_id(sid2), .seq_num(seq2), .msg_count(cnt2),
        .is_heartbeat(hb2), .is_end_session(eos2), .seq_gap(gap2), .gap_len(gl2),
        .seq_stale(st2), .session_change(sc2), .trunc_err(tr2), .expected_seq(ex2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [79:0] sess;
        logic [63:0] seq;
        logic [15:0] cnt;
        bit          sc;
        bit          gap;
        bit          stale;
        logic [63:0] gl;
        logic [63:0] exp_seq;
        bit          pre;      // preceded by a 6-beat partial packet (SOP lands mid-header)
    } vec_t;

    vec_t tbl[13];

    // Reference tracker state
    bit          m_sync = 1'b0;
    logic [79:0] m_sess = '0;
    logic [63:0] m_exp  = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [79:0] s, input logic [63:0] q, input logic [15:0] c,
                                input bit sc, input bit gap, input bit stale,
                                input logic [63:0] gl, input logic [63:0] ex, input bit pre);
        vec_t v;
        v.sess = s; v.seq = q; v.cnt = c; v.sc = sc; v.gap = gap; v.stale = stale;
        v.gl = gl; v.exp_seq = ex; v.pre = pre;
        return v;
    endfunction

    // Expected outcome of a completed header given the tracker rules.
    function automatic vec_t model_predict(input logic [79:0] s, input logic [63:0] q, input logic [15:0] c);
        vec_t v;
        v.sess  = s; v.seq = q; v.cnt = c; v.pre = 1'b0;
        v.sc    = !m_sync || (s != m_sess);
        v.gap   = !v.sc && (q > m_exp);
        v.stale = !v.sc && (q < m_exp);
        v.gl    = v.gap ? q - m_exp : 64'd0;
        if (v.sc)                           v.exp_seq = (c == 16'hFFFF) ? q : q + 64'(c);
        else if (c == 0 || c == 16'hFFFF)   v.exp_seq = (q > m_exp) ? q : m_exp;
        else if (q < m_exp)                 v.exp_seq = m_exp;
        else                                v.exp_seq = q + 64'(c);
        return v;
    endfunction

    task automatic model_commit(input vec_t v);
        m_exp  = v.exp_seq;
        m_sess = v.sess;
        m_sync = (v.cnt != 16'hFFFF);
    endtask

    task automatic idle1();
        v1 = 1'b0; sop1 = 1'b0; eop1 = 1'b0;
        @(posedge clk); #1;
        chk("idle_hdr_valid", hv1, 1'b0);
        chk("idle_expected_seq", ex1, m_exp);
    endtask

    // Drive one packet into DUT 1 and check every beat's outputs.
    task automatic send_pkt(input vec_t v, input int nbeats, input int eop_beat,
                            input bit sop_trunc, input bit gaps);
        logic [159:0]  hdr;
        logic [W1-1:0] beat;
        int            a;
        bit            hdr_now, trunc_now, done;
        hdr  = {v.sess, v.seq, v.cnt};
        done = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                v1 = 1'b0; sop1 = 1'($urandom); eop1 = 1'($urandom); d1 = {$urandom, $urandom};
                @(posedge clk); #1;
                chk("gap_hdr_valid", hv1, 1'b0);
                chk("gap_trunc_err", tr1, 1'b0);
            end
            for (int k = 0; k < int'(NB1); k++) begin
                a = b * int'(NB1) + k;
                if (a >= int'(OFS1) && a < int'(OFS1) + 20) beat[8*k +: 8] = hdr[159 - 8*(a - int'(OFS1)) -: 8];
                else                                        beat[8*k +: 8] = 8'($urandom);
            end
            v1 = 1'b1; sop1 = (b == 0); eop1 = (b == eop_beat); d1 = beat;
            @(posedge clk); #1;
            v1 = 1'b0; sop1 = 1'b0; eop1 = 1'b0;
            hdr_now   = (b == LAST1) && (eop_beat < 0 || eop_beat >= LAST1);
            trunc_now = (b == 0 && sop_trunc) || (b == eop_beat && b < LAST1);
            chk("hdr_valid", hv1, hdr_now);
            chk("trunc_err", tr1, trunc_now);
            if (trunc_now) chk("expected_seq_on_trunc", ex1, m_exp);
            if (hdr_now) begin
                done = 1'b1;
                chk("session_id", sid1, v.sess);
                chk("seq_num", seq1, v.seq);
                chk("msg_count", cnt1, v.cnt);
                chk("is_heartbeat", hb1, v.cnt == 16'h0000);
                chk("is_end_session", eos1, v.cnt == 16'hFFFF);
                chk("session_change", sc1, v.sc);
                chk("seq_gap", gap1, v.gap);
                chk("gap_len", gl1, v.gl);
                chk("seq_stale", st1, v.stale);
                chk("expected_seq", ex1, v.exp_seq);
            end
            if (done && b == LAST1 + 1) chk("seq_num_hold", seq1, v.seq);
            if (b == eop_beat) break;
        end
    endtask

    function automatic logic [W2-1:0] beat2(input logic [159:0] h, input int b);
        logic [W2-1:0] r;
        int            idx;
        for (int k = 0; k < 16; k++) begin
            idx = b * 16 + k;
            if (idx < 20) r[8*k +: 8] = h[159 - 8*idx -: 8];
            else          r[8*k +: 8] = 8'($urandom);
        end
        return r;
    endfunction

    // Three-beat packet on DUT 2 with in_valid low every other cycle;
    // optionally reset in the idle cycle after beat 0.
    task automatic pkt2(input bit rst_mid);
        logic [159:0] h2;
        bit           exp_hv;
        h2 = {S1, 64'd77, 16'd3};
        for (int b = 0; b < 3; b++) begin
            v2 = 1'b1; sop2 = (b == 0); eop2 = (b == 2); d2 = beat2(h2, b);
            @(posedge clk); #1;
            v2 = 1'b0; sop2 = 1'b0; eop2 = 1'b0; d2 = {$urandom, $urandom, $urandom, $urandom};
            exp_hv = (b == 1) && !rst_mid;
            chk("w128_hdr_valid", hv2, exp_hv);
            chk("w128_trunc_err", tr2, 1'b0);
            if (exp_hv) begin
                chk("w128_session_id", sid2, S1);
                chk("w128_seq_num", seq2, 64'd77);
                chk("w128_msg_count", cnt2, 16'd3);
                chk("w128_session_change", sc2, 1'b1);
                chk("w128_seq_stale", st2, 1'b0);
                chk("w128_expected_seq", ex2, 64'd80);
            end
            if (b == 0 && rst_mid) rst2 = 1'b1;
            @(posedge clk); #1;
            rst2 = 1'b0;
            chk("w128_idle_hdr_valid", hv2, 1'b0);
            if (b == 0 && rst_mid) begin
                chk("w128_rst_session_id", sid2, 80'd0);
                chk("w128_rst_seq_num", seq2, 64'd0);
                chk("w128_rst_msg_count", cnt2, 16'd0);
                chk("w128_rst_expected_seq", ex2, 64'd0);
                chk("w128_rst_flags", {sc2, gap2, st2, hb2, eos2, tr2}, 6'd0);
                chk("w128_rst_gap_len", gl2, 64'd0);
            end
            if (b == 1 && !rst_mid) chk("w128_seq_num_hold", seq2, 64'd77);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t        v;
        logic [79:0] s;
        logic [63:0] q;
        logic [15:0] c;
        int          r, eb, extra;

        rst1 = 1'b1; v1 = 1'b0; sop1 = 1'b0; eop1 = 1'b0; d1 = '0;
        rst2 = 1'b1; v2 = 1'b0; sop2 = 1'b0; eop2 = 1'b0; d2 = '0;

        //            sess seq  cnt        sc gap st gl  exp  pre
        tbl[0]  = mk(S1,  1,   3,          1, 0, 0, 0,  4,   0);
        tbl[1]  = mk(S1,  4,   2,          0, 0, 0, 0,  6,   0);
        tbl[2]  = mk(S1,  10,  1,          0, 1, 0, 4,  11,  0);
        tbl[3]  = mk(S1,  5,   1,          0, 0, 1, 0,  11,  0);
        tbl[4]  = mk(S1,  11,  0,          0, 0, 0, 0,  11,  0);
        tbl[5]  = mk(S1,  11,  0,          0, 0, 0, 0,  11,  1);
        tbl[6]  = mk(S1,  11,  16'hFFFF,   0, 0, 0, 0,  11,  0);
        tbl[7]  = mk(S1,  1,   3,          1, 0, 0, 0,  4,   0);
        tbl[8]  = mk(S2,  50,  4,          1, 0, 0, 0,  54,  0);
        tbl[9]  = mk(S2,  54,  1,          0, 0, 0, 0,  55,  0);
        tbl[10] = mk(S2,  60,  0,          0, 1, 0, 5,  60,  0);
        tbl[11] = mk(S2,  58,  16'hFFFF,   0, 0, 1, 0,  60,  0);
        tbl[12] = mk(S2,  60,  2,          1, 0, 0, 0,  62,  0);

        repeat (3) @(posedge clk);
        #1;
        rst1 = 1'b0; rst2 = 1'b0;
        chk("reset_hdr_valid", hv1, 1'b0);
        chk("reset_trunc_err", tr1, 1'b0);
        chk("reset_expected_seq", ex1, 64'd0);
        chk("reset_session_id", sid1, 80'd0);
        chk("reset_flags", {sc1, gap1, st1, hb1, eos1}, 5'd0);

        for (int i = 0; i < 13; i++) begin
            if (i == 5) begin
                // EOP on beat 6: header incomplete, tracker untouched
                send_pkt(tbl[i], 7, 6, 1'b0, 1'b0);
                idle1();
            end
            if (tbl[i].pre) send_pkt(tbl[i], 6, -1, 1'b0, 1'b0);
            send_pkt(tbl[i], 10, 9, tbl[i].pre, (i % 2) == 1);
            model_commit(tbl[i]);
        end

        for (int n = 0; n < 40; n++) begin
            s = ($urandom_range(0, 3) == 0) ? S2 : S1;
            case ($urandom_range(0, 3))
                0:       q = m_exp + 64'($urandom_range(1, 5));
                1:       q = m_exp - 64'($urandom_range(1, 3));
                default: q = m_exp;
            endcase
            r = $urandom_range(0, 9);
            c = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom_range(1, 9));
            v = model_predict(s, q, c);
            if ($urandom_range(0, 7) == 0) begin
                eb = $urandom_range(0, LAST1 - 1);
                send_pkt(v, eb + 1, eb, 1'b0, 1'($urandom));
            end else begin
                extra = $urandom_range(0, 3);
                send_pkt(v, LAST1 + 1 + extra, ($urandom_range(0, 7) == 0) ? -1 : LAST1 + extra,
                         1'b0, 1'($urandom));
                model_commit(v);
            end
        end
        idle1();

        pkt2(1'b0);
        pkt2(1'b1);
        pkt2(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
